// File: rtl/dmem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : dmem_pkg                                                   |
// | Description : Shared types, constants and helpers for the data-memory    |
// |               responder: FSM state encoding, wait-counter width, and    |
// |               little-endian byte-lane helpers.                           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package dmem_pkg;

    // Responder control states; two bits leave one unused encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Wide enough for the full 0..15 wait-state range.
    localparam int CNT_W = 4;

    // Pick one byte out of a word; lane 0 is bits [7:0] (little-endian).
    function automatic logic [7:0] lane_select(input logic [31:0] word, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

    // One-hot byte write enable for a single lane.
    function automatic logic [3:0] lane_mask(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : dmem_array                                                 |
// | Description : Single-port synchronous RAM, 32-bit words with a 4-bit     |
// |               byte write enable and a registered, read-first output.     |
// |               Depth is 2^(ADDR_W-2) words. Contents are never reset.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module dmem_array #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              en_i,
    input  logic [3:0]        we_i,
    input  logic [ADDR_W-3:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    localparam int c_DEPTH = 2 ** (ADDR_W - 2);

    logic [31:0] mem_q [c_DEPTH];
    logic [31:0] rdata_q;

    // Enabled access: byte-masked write and read of the old word in one edge.
    always_ff @(posedge clk) begin
        if (en_i) begin
            for (int i = 0; i < 4; i++) begin
                if (we_i[i]) begin
                    mem_q[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
                end
            end
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : dmem_responder                                             |
// | Description : Memory-side responder for the load/store port. Accepts    |
// |               one request via valid/ready, spends WAIT_STATES cycles in |
// |               WAIT, performs the RAM access on the edge entering RESP   |
// |               and holds the response until the requester takes it.      |
// |               Optional build macro: DMEM_ALIGN_CHECK_EN rejects word    |
// |               accesses whose addr[1:0] is non-zero.                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        Reset_n,
    input  logic        Req_valid,
    output logic        Req_ready,
    input  logic        Req_we,
    input  logic        Req_byte,
    input  logic [31:0] Req_addr,
    input  logic [31:0] Req_wdata,
    output logic        Rsp_valid,
    input  logic        Rsp_ready,
    output logic [31:0] Rsp_rdata,
    output logic        Rsp_err
);

    localparam logic [CNT_W-1:0] c_WAIT_INIT = CNT_W'(WAIT_STATES);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);
    localparam bit               c_SKIP_WAIT = (WAIT_STATES == 0);

    // Control and latched-request registers
    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               we_q;
    logic               byte_q;
    logic               err_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [31:0]        wdata_q;
    logic               req_ready_q;
    logic               rsp_valid_q;
    logic               rsp_err_q;

    // Datapath wires
    logic               w_accept;
    logic               w_enter_resp;
    logic               w_req_err;
    logic               w_from_req;
    logic               w_op_we;
    logic               w_op_byte;
    logic               w_op_err;
    logic [ADDR_W-1:0]  w_op_addr;
    logic [31:0]        w_op_wdata;
    logic               w_ram_en;
    logic [3:0]         w_ram_be;
    logic [31:0]        w_ram_wdata;
    logic [31:0]        w_ram_rdata;

    // Request rejection: out-of-range always, misaligned word only when enabled.
    always_comb begin
        w_req_err = |Req_addr[31:ADDR_W];
`ifdef DMEM_ALIGN_CHECK_EN
        if (!Req_byte && (Req_addr[1:0] != 2'b00)) begin
            w_req_err = 1'b1;
        end
`endif
    end

    assign w_accept = (state_q == ST_IDLE) && Req_valid;

    // The RAM access belongs to the RESP-entry edge. With zero wait states
    // that edge is the accept edge itself, so operands come straight from
    // the request port; otherwise they come from the latched copy.
    assign w_enter_resp = ((state_q == ST_WAIT) && (cnt_q <= c_CNT_ONE))
                        || (c_SKIP_WAIT && w_accept);
    assign w_from_req   = (state_q == ST_IDLE);

    // Operand selection between live request and latched request.
    always_comb begin
        w_op_we    = we_q;
        w_op_byte  = byte_q;
        w_op_err   = err_q;
        w_op_addr  = addr_q;
        w_op_wdata = wdata_q;
        if (w_from_req) begin
            w_op_we    = Req_we;
            w_op_byte  = Req_byte;
            w_op_err   = w_req_err;
            w_op_addr  = Req_addr[ADDR_W-1:0];
            w_op_wdata = Req_wdata;
        end
    end

    // RAM controls: rejected requests never touch the array, and the reset
    // term keeps a held-in-reset request from committing a write.
    always_comb begin
        w_ram_en    = w_enter_resp && !w_op_err && Reset_n;
        w_ram_be    = 4'h0;
        w_ram_wdata = w_op_wdata;
        if (w_op_we) begin
            w_ram_be = w_op_byte ? lane_mask(w_op_addr[1:0]) : 4'hF;
        end
        if (w_op_byte) begin
            w_ram_wdata = {4{w_op_wdata[7:0]}};
        end
    end

    dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .en_i    (w_ram_en),
        .we_i    (w_ram_be),
        .addr_i  (w_op_addr[ADDR_W-1:2]),
        .wdata_i (w_ram_wdata),
        .rdata_o (w_ram_rdata)
    );

    // Control FSM: request capture, wait-state countdown, response handshake.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            byte_q      <= 1'b0;
            err_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (Req_valid) begin
                        we_q        <= Req_we;
                        byte_q      <= Req_byte;
                        err_q       <= w_req_err;
                        addr_q      <= Req_addr[ADDR_W-1:0];
                        wdata_q     <= Req_wdata;
                        req_ready_q <= 1'b0;
                        if (c_SKIP_WAIT) begin
                            state_q     <= ST_RESP;
                            cnt_q       <= '0;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= w_req_err;
                        end else begin
                            state_q     <= ST_WAIT;
                            cnt_q       <= c_WAIT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    // Leave on the edge that ends the cycle with count 1.
                    if (cnt_q <= c_CNT_ONE) begin
                        state_q     <= ST_RESP;
                        cnt_q       <= '0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= err_q;
                    end else begin
                        cnt_q       <= cnt_q - c_CNT_ONE;
                    end
                end
                ST_RESP: begin
                    if (Rsp_ready) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cnt_q       <= '0;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Load data: the RAM's registered word, lane-selected and zero-extended
    // for byte loads; zero for stores, errors and outside RESP.
    always_comb begin
        Rsp_rdata = 32'h0;
        if (rsp_valid_q && !rsp_err_q && !we_q) begin
            Rsp_rdata = byte_q ? {24'h0, lane_select(w_ram_rdata, addr_q[1:0])}
                               : w_ram_rdata;
        end
    end

    assign Req_ready = req_ready_q;
    assign Rsp_valid = rsp_valid_q;
    assign Rsp_err   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_dmem_responder                                          |
// | Description : Self-checking bench for dmem_responder: directed vector   |
// |               table, back-pressure and reset-in-WAIT sequences, then    |
// |               randomized traffic against a byte-array reference model.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_dmem_responder;

    localparam int ADDR_W      = 10;
    localparam int WAIT_STATES = 2;
    localparam int NBYTES      = 2 ** ADDR_W;
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        Reset_n;
    logic        Req_valid;
    logic        Req_ready;
    logic        Req_we;
    logic        Req_byte;
    logic [31:0] Req_addr;
    logic [31:0] Req_wdata;
    logic        Rsp_valid;
    logic        Rsp_ready;
    logic [31:0] Rsp_rdata;
    logic        Rsp_err;

    int errors = 0;
    int checks = 0;

    // Reference storage as a flat little-endian byte array.
    logic [7:0] mem_b [NBYTES];

    typedef struct {
        logic        we;
        logic        byt;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    dmem_responder #(
        .ADDR_W      (ADDR_W),
        .WAIT_STATES (WAIT_STATES)
    ) dut (
        .clk       (clk),
        .Reset_n   (Reset_n),
        .Req_valid (Req_valid),
        .Req_ready (Req_ready),
        .Req_we    (Req_we),
        .Req_byte  (Req_byte),
        .Req_addr  (Req_addr),
        .Req_wdata (Req_wdata),
        .Rsp_valid (Rsp_valid),
        .Rsp_ready (Rsp_ready),
        .Rsp_rdata (Rsp_rdata),
        .Rsp_err   (Rsp_err)
    );

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference behaviour straight from the access rules.
    function automatic void model_op(input logic we, input logic byt, input logic [31:0] addr,
                                     input logic [31:0] wdata,
                                     output logic [31:0] rd, output logic er);
        int a;
        int wb;
        er = ((addr >> ADDR_W) != 0) || (ALIGN && !byt && (addr[1:0] != 2'b00));
        rd = 32'h0;
        if (!er) begin
            a  = int'(addr % NBYTES);
            wb = a - (a % 4);
            if (we) begin
                if (byt) begin
                    mem_b[a] = wdata[7:0];
                end else begin
                    for (int i = 0; i < 4; i++) mem_b[wb + i] = wdata[8*i +: 8];
                end
            end else if (byt) begin
                rd = {24'h0, mem_b[a]};
            end else begin
                rd = {mem_b[wb + 3], mem_b[wb + 2], mem_b[wb + 1], mem_b[wb]};
            end
        end
    endfunction

    // One full transaction; bp > 0 holds Rsp_ready low for bp RESP cycles.
    task automatic do_req(input logic we, input logic byt, input logic [31:0] addr,
                          input logic [31:0] wdata, input int bp,
                          output logic [31:0] rd, output logic er);
        int n;
        bit busy_ready;
        @(negedge clk);
        check1("req_ready_idle", Req_ready, 1'b1);
        Req_valid = 1'b1;
        Req_we    = we;
        Req_byte  = byt;
        Req_addr  = addr;
        Req_wdata = wdata;
        Rsp_ready = (bp == 0);
        @(posedge clk);
        #1;
        Req_valid = 1'b0;
        n = 0;
        busy_ready = 1'b0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (Rsp_valid) break;
            if (Req_ready) busy_ready = 1'b1;
        end
        check32("latency", 32'(n), 32'(WAIT_STATES + 1));
        check1("req_ready_busy", busy_ready, 1'b0);
        rd = Rsp_rdata;
        er = Rsp_err;
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            check1("bp_valid", Rsp_valid, 1'b1);
            check32("bp_rdata_stable", Rsp_rdata, rd);
            check1("bp_err_stable", Rsp_err, er);
            check1("bp_req_ready", Req_ready, 1'b0);
        end
        Rsp_ready = 1'b1;
        @(negedge clk);
        check1("rsp_done", Rsp_valid, 1'b0);
        check1("rsp_done_ready", Req_ready, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] mrd;
        logic        mer;
        logic        r_we;
        logic        r_byt;
        logic [31:0] r_addr;
        logic [31:0] r_wdata;
        int          r_bp;

        Reset_n   = 1'b0;
        Req_valid = 1'b0;
        Req_we    = 1'b0;
        Req_byte  = 1'b0;
        Req_addr  = 32'h0;
        Req_wdata = 32'h0;
        Rsp_ready = 1'b1;
        for (int i = 0; i < NBYTES; i++) mem_b[i] = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check1("reset_req_ready", Req_ready, 1'b1);
        check1("reset_rsp_valid", Rsp_valid, 1'b0);
        check32("reset_rsp_rdata", Rsp_rdata, 32'h0);
        check1("reset_rsp_err", Rsp_err, 1'b0);
        Reset_n = 1'b1;

        // we, byte, addr, wdata, expected rdata, expected err
        vecs.push_back('{1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 32'h0000_0012, 32'hFFFF_FF5A, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'hDE5A_BEEF, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h0000_0012, 32'h0,         32'h0000_005A, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h0000_0013, 32'h0,         32'h0000_00DE, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h0000_0010, 32'h0,         32'h0000_00EF, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'h0000_0000, 32'hCAFE_F00D, 32'h0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'h0000_0020, 32'hA5A5_A5A5, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 32'h0000_0400, 32'h0,         32'h0, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 32'h0000_0400, 32'h1111_1111, 32'h0, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 32'h0000_0401, 32'h0000_0077, 32'h0, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 32'h0000_0000, 32'h0,         32'hCAFE_F00D, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 32'h8000_0010, 32'h0,         32'h0, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 32'h0000_0011, 32'h0,         ALIGN ? 32'h0 : 32'hDE5A_BEEF, ALIGN});
        vecs.push_back('{1'b1, 1'b0, 32'h0000_0022, 32'h0BAD_0BAD, 32'h0, ALIGN});
        vecs.push_back('{1'b0, 1'b0, 32'h0000_0020, 32'h0,         ALIGN ? 32'hA5A5_A5A5 : 32'h0BAD_0BAD, 1'b0});

        foreach (vecs[i]) begin
            do_req(vecs[i].we, vecs[i].byt, vecs[i].addr, vecs[i].wdata, 0, rd, er);
            model_op(vecs[i].we, vecs[i].byt, vecs[i].addr, vecs[i].wdata, mrd, mer);
            check32($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check1($sformatf("vec%0d_err", i), er, vecs[i].exp_err);
        end

        // Back-pressure: response held for 5 cycles with Rsp_ready low.
        do_req(1'b0, 1'b0, 32'h0000_0010, 32'h0, 5, rd, er);
        check32("bp_load_rdata", rd, 32'hDE5A_BEEF);
        check1("bp_load_err", er, 1'b0);

        // Reset during WAIT: store is abandoned, outputs drop immediately.
        model_op(1'b0, 1'b0, 32'h0000_0020, 32'h0, mrd, mer);
        @(negedge clk);
        Req_valid = 1'b1;
        Req_we    = 1'b1;
        Req_byte  = 1'b0;
        Req_addr  = 32'h0000_0020;
        Req_wdata = 32'h1234_5678;
        Rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        Req_valid = 1'b0;
        @(negedge clk);
        check1("rstwait_in_wait", Req_ready, 1'b0);
        #1;
        Reset_n = 1'b0;
        #1;
        check1("rstwait_req_ready", Req_ready, 1'b1);
        check1("rstwait_rsp_valid", Rsp_valid, 1'b0);
        check32("rstwait_rsp_rdata", Rsp_rdata, 32'h0);
        check1("rstwait_rsp_err", Rsp_err, 1'b0);
        @(posedge clk);
        @(negedge clk);
        Reset_n = 1'b1;
        do_req(1'b0, 1'b0, 32'h0000_0020, 32'h0, 0, rd, er);
        check32("rstwait_old_data", rd, mrd);
        check1("rstwait_old_err", er, 1'b0);

        // Randomized traffic: fill every word, then mixed operations.
        for (int w = 0; w < NBYTES / 4; w++) begin
            r_wdata = $urandom;
            do_req(1'b1, 1'b0, 32'(w * 4), r_wdata, 0, rd, er);
            model_op(1'b1, 1'b0, 32'(w * 4), r_wdata, mrd, mer);
            check1("fill_err", er, mer);
        end
        for (int k = 0; k < 300; k++) begin
            r_we    = 1'($urandom_range(0, 1));
            r_byt   = 1'($urandom_range(0, 1));
            r_wdata = $urandom;
            r_addr  = 32'($urandom_range(0, NBYTES - 1));
            if ($urandom_range(0, 9) == 0) begin
                r_addr = r_addr | (32'h1 << $urandom_range(ADDR_W, 31));
            end
            r_bp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            do_req(r_we, r_byt, r_addr, r_wdata, r_bp, rd, er);
            model_op(r_we, r_byt, r_addr, r_wdata, mrd, mer);
            check32($sformatf("rand%0d_rdata a=%08h", k, r_addr), rd, mrd);
            check1($sformatf("rand%0d_err a=%08h", k, r_addr), er, mer);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
